// File: rtl/write_ptr_full.sv
// Write-side pointer/flag controller for the async FIFO; optional sticky overflow under WR_PTR_OVF_EN.
// Latency: an accepted write updates pointers, full, almost-full and level on the next i_wr_clk edge.
// Backpressure: writes are ignored while o_wr_full=1; flags lag reads by the synchroniser delay.
module write_ptr_full #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 i_wr_clk,
  input  logic                 i_wrrst_n,
  input  logic                 i_wr_inc,
  input  logic [ADDR_SIZE:0]   i_gray_q2_rdptr,
  input  logic                 i_ovf_clr,
  output logic                 o_wr_full,
  output logic                 o_wr_almost_full,
  output logic                 o_wr_overflow,
  output logic [ADDR_SIZE:0]   o_wr_level,
  output logic [ADDR_SIZE-1:0] o_wr_addr,
  output logic [ADDR_SIZE:0]   o_gray_wrptr
);

  localparam logic [ADDR_SIZE:0] AF_THRESH = (ADDR_SIZE+1)'((2**ADDR_SIZE) - AF_MARGIN);

  logic [ADDR_SIZE:0] r_wr_bin;
  logic [ADDR_SIZE:0] r_gray_wrptr;
  logic               r_wr_full;
  logic               r_wr_almost_full;
  logic [ADDR_SIZE:0] r_wr_level;

  logic [ADDR_SIZE:0] w_wr_bin_next;
  logic [ADDR_SIZE:0] w_gray_next;
  logic [ADDR_SIZE:0] w_rd_bin;
  logic [ADDR_SIZE:0] w_level_next;
  logic [ADDR_SIZE:0] w_full_cmp;
  logic               w_full_next;
  logic               w_af_next;

  assign w_wr_bin_next = r_wr_bin + (ADDR_SIZE+1)'(i_wr_inc & ~r_wr_full);
  assign w_gray_next   = (w_wr_bin_next >> 1) ^ w_wr_bin_next;

  // Gray-to-binary: each bit is the XOR of itself and every more-significant bit.
  always_comb begin
    w_rd_bin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      w_rd_bin[i] = ^(i_gray_q2_rdptr >> i);
    end
  end

  // Full when write leads read by exactly one lap: top two Gray bits inverted, rest equal.
  assign w_full_cmp   = {~i_gray_q2_rdptr[ADDR_SIZE:ADDR_SIZE-1], i_gray_q2_rdptr[ADDR_SIZE-2:0]};
  assign w_full_next  = (w_gray_next == w_full_cmp);
  assign w_level_next = w_wr_bin_next - w_rd_bin;
  assign w_af_next    = (w_level_next >= AF_THRESH);

  always_ff @(posedge i_wr_clk or negedge i_wrrst_n) begin
    if (!i_wrrst_n) begin
      r_wr_bin         <= '0;
      r_gray_wrptr     <= '0;
      r_wr_full        <= 1'b0;
      r_wr_almost_full <= 1'b0;
      r_wr_level       <= '0;
    end else begin
      r_wr_bin         <= w_wr_bin_next;
      r_gray_wrptr     <= w_gray_next;
      r_wr_full        <= w_full_next;
      r_wr_almost_full <= w_af_next;
      r_wr_level       <= w_level_next;
    end
  end

`ifdef WR_PTR_OVF_EN
  logic r_wr_overflow;

  // Set has priority over clear so a coincident failed write is never lost.
  always_ff @(posedge i_wr_clk or negedge i_wrrst_n) begin
    if (!i_wrrst_n) begin
      r_wr_overflow <= 1'b0;
    end else if (i_wr_inc && r_wr_full) begin
      r_wr_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      r_wr_overflow <= 1'b0;
    end
  end

  assign o_wr_overflow = r_wr_overflow;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = i_ovf_clr;
  assign o_wr_overflow    = 1'b0;
`endif

  assign o_wr_full        = r_wr_full;
  assign o_wr_almost_full = r_wr_almost_full;
  assign o_wr_level       = r_wr_level;
  assign o_wr_addr        = r_wr_bin[ADDR_SIZE-1:0];
  assign o_gray_wrptr     = r_gray_wrptr;

endmodule

// File: tb/tb_write_ptr_full.sv
// Directed bench for write_ptr_full (ADDR_SIZE=4, AF_MARGIN=2); expectations hand-computed.
module tb_write_ptr_full;

  logic       clk;
  logic       rst_n;
  logic       wr_inc;
  logic [4:0] rq2;
  logic       ovf_clr;
  logic       wr_full;
  logic       wr_af;
  logic       wr_ovf;
  logic [4:0] wr_level;
  logic [3:0] wr_addr;
  logic [4:0] gray_wr;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef WR_PTR_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  write_ptr_full #(.ADDR_SIZE(4), .AF_MARGIN(2)) dut (
    .i_wr_clk        (clk),
    .i_wrrst_n       (rst_n),
    .i_wr_inc        (wr_inc),
    .i_gray_q2_rdptr (rq2),
    .i_ovf_clr       (ovf_clr),
    .o_wr_full       (wr_full),
    .o_wr_almost_full(wr_af),
    .o_wr_overflow   (wr_ovf),
    .o_wr_level      (wr_level),
    .o_wr_addr       (wr_addr),
    .o_gray_wrptr    (gray_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [4:0] wb;
  logic [4:0] prev_gray;

  initial begin
    rst_n   = 1'b1;
    wr_inc  = 1'b0;
    rq2     = 5'd0;
    ovf_clr = 1'b0;

    // 1. async reset mid-cycle, outputs clear before the next edge
    #3 rst_n = 1'b0;
    #1;
    check("rst_full",  wr_full,  0);
    check("rst_af",    wr_af,    0);
    check("rst_ovf",   wr_ovf,   0);
    check("rst_level", wr_level, 0);
    check("rst_addr",  wr_addr,  0);
    check("rst_gray",  gray_wr,  0);
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    step();
    check("rel_addr",  wr_addr, 0);
    check("rel_gray",  gray_wr, 0);
    check("rel_level", wr_level, 0);
    check("rel_full",  wr_full, 0);

    // 2. fill 16 words with reader parked at 0
    for (int i = 0; i < 16; i++) begin
      check("fill_addr", wr_addr, i);
      wr_inc = 1'b1;
      step();
      if (i == 12) check("af_13", wr_af, 0);
      if (i == 13) check("af_14", wr_af, 1);
      if (i == 14) check("full_15", wr_full, 0);
    end
    wr_inc = 1'b0;
    check("fill_addr_wrap", wr_addr, 0);
    check("fill_full",  wr_full, 1);
    check("fill_level", wr_level, 16);
    check("fill_gray",  gray_wr, 5'b11000);
    check("fill_ovf0",  wr_ovf, 0);

    // 3. writes while full
    wr_inc = 1'b1;
    repeat (3) step();
    check("ovr_gray",  gray_wr, 5'b11000);
    check("ovr_level", wr_level, 16);
    check("ovr_ovf",   wr_ovf, OVF_EXP);
    ovf_clr = 1'b1;
    step();
    check("ovf_setwins", wr_ovf, OVF_EXP);
    wr_inc = 1'b0;
    step();
    check("ovf_clr", wr_ovf, 0);
    ovf_clr = 1'b0;

    // 4. reader advances to 4
    rq2 = 5'b00110;
    wr_inc = 1'b1;
    step();
    check("rel_blocked_gray", gray_wr, 5'b11000);
    check("rel_full",  wr_full, 0);
    check("rel_level", wr_level, 12);
    check("rel_af",    wr_af, 0);
    repeat (4) step();
    wr_inc = 1'b0;
    check("refill_full", wr_full, 1);
    check("refill_gray", gray_wr, 5'b11110);
    check("refill_level", wr_level, 16);

    // 5. reader tracking writer through a pointer wrap
    rst_n = 1'b0;
    rq2 = 5'd0;
    #2 rst_n = 1'b1;
    step();
    wb = 5'd0;
    for (int k = 0; k < 40; k++) begin
      rq2 = gray(wb);
      prev_gray = gray_wr;
      wr_inc = 1'b1;
      step();
      wb = wb + 5'd1;
      check("trk_gray", gray_wr, gray(wb));
      check("trk_1bit", $countones(prev_gray ^ gray_wr), 1);
      check("trk_lvl", wr_level <= 5'd1, 1);
      check("trk_full", wr_full, 0);
      if (wb == 5'd0) check("trk_wrap_prev", prev_gray, 5'b10000);
    end
    wr_inc = 1'b0;

    // 6. async reset while full
    rq2 = gray(wb);
    wr_inc = 1'b1;
    repeat (16) step();
    wr_inc = 1'b0;
    check("f6_full", wr_full, 1);
    check("f6_gray", gray_wr, 5'b10100);
    #2 rst_n = 1'b0;
    #1;
    check("f6_rst_full",  wr_full, 0);
    check("f6_rst_level", wr_level, 0);
    check("f6_rst_addr",  wr_addr, 0);
    check("f6_rst_gray",  gray_wr, 0);
    rq2 = 5'd0;
    #2 rst_n = 1'b1;
    wr_inc = 1'b1;
    step();
    wr_inc = 1'b0;
    check("f6_first_addr", wr_addr, 1);
    check("f6_first_level", wr_level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
